// File: rtl/ball_flight.sv
// ball_flight
// Receiving end of the bowler's throw interface. It accepts one delivery,
// moves the ball once per frame tick, judges the batsman's swing timing and
// reports the outcome of the delivery to the scoring logic.
//
// Ports:
//   clock        in   system clock
//   reset        in   asynchronous active-high reset
//   tick         in   one-clock frame-rate enable pulse
//   gameOver     in   aborts a delivery and blocks new ones
//   throw        in   bowler delivery request (level)
//   dy, dx       in   vertical / horizontal speed in pixels per tick
//   swing        in   batsman swing button (level, already synchronised)
//   accept       out  one-clock pulse when a throw is latched
//   busy         out  delivery in progress (FLIGHT or HIT)
//   ball_x       out  ball x position
//   ball_y       out  ball y position (grows downward)
//   ball_visible out  ball should be drawn
//   result_valid out  one-clock pulse when runs/wicket are final
//   runs         out  runs scored (0,1,2,4,6)
//   wicket       out  batsman out
//
// HIT_X_LO+15 must stay below STUMP_X so a hit is always possible before
// the ball reaches the stumps.
module ball_flight #(
   parameter int X_START   = 16,
   parameter int Y_START   = 40,
   parameter int GROUND_Y  = 100,
   parameter int HIT_X_LO  = 120,
   parameter int STUMP_X   = 150,
   parameter int STUMP_TOP = 80,
   parameter int HIT_TICKS = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick,
   input  logic       gameOver,
   input  logic       throw,
   input  logic [3:0] dy,
   input  logic [3:0] dx,
   input  logic       swing,
   output logic       accept,
   output logic       busy,
   output logic [7:0] ball_x,
   output logic [6:0] ball_y,
   output logic       ball_visible,
   output logic       result_valid,
   output logic [2:0] runs,
   output logic       wicket
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FLIGHT = 2'd1,
      HIT    = 2'd2,
      RESULT = 2'd3
   } state_t;

   localparam logic [7:0] LP_X_START   = 8'(X_START);
   localparam logic [6:0] LP_Y_START   = 7'(Y_START);
   localparam logic [7:0] LP_GROUND_Y  = 8'(GROUND_Y);
   localparam logic [7:0] LP_HIT_X_LO  = 8'(HIT_X_LO);
   localparam logic [7:0] LP_HIT_X_HI  = 8'(HIT_X_LO + 15);
   localparam logic [7:0] LP_STUMP_X   = 8'(STUMP_X);
   localparam logic [6:0] LP_STUMP_TOP = 7'(STUMP_TOP);
   localparam logic [7:0] LP_HIT_LAST  = 8'(HIT_TICKS - 1);

   state_t     r_state;
   logic [3:0] r_dx;
   logic [3:0] r_dy;
   logic [7:0] r_ballX;
   logic [6:0] r_ballY;
   logic       r_dirUp;
   logic       r_swingPrev;
   logic       r_swung;
   logic [7:0] r_hitCnt;
   logic       r_accept;
   logic       r_busy;
   logic       r_visible;
   logic       r_resultValid;
   logic [2:0] r_runs;
   logic       r_wicket;

   logic       w_swingFirst;
   logic       w_inWindow;
   logic       w_hitNow;
   logic [7:0] w_offset;
   logic [2:0] w_hitRuns;
   logic [7:0] w_nextX;
   logic [7:0] w_sumY;
   logic [6:0] w_nextY;
   logic       w_bounce;
   logic [7:0] w_backX;

   // Swing judgement uses the current (pre-tick) x, and only the first
   // rising edge of swing in a delivery is ever considered.
   assign w_swingFirst = swing & ~r_swingPrev & ~r_swung;
   assign w_inWindow   = (r_ballX >= LP_HIT_X_LO) && (r_ballX <= LP_HIT_X_HI);
   assign w_hitNow     = w_swingFirst & w_inWindow;
   assign w_offset     = r_ballX - LP_HIT_X_LO;

   // Quarter of the hit window selects the runs: early edge 1, sweet spots
   // 4 and 6, late edge 2.
   always_comb begin
      w_hitRuns = 3'd1;
      case (w_offset[3:2])
         2'd0: w_hitRuns = 3'd1;
         2'd1: w_hitRuns = 3'd4;
         2'd2: w_hitRuns = 3'd6;
         2'd3: w_hitRuns = 3'd2;
         default: w_hitRuns = 3'd1;
      endcase
   end

   // Next flight position; the y sum is taken 8 bits wide so a large dy
   // cannot wrap before the ground compare. After the bounce y only
   // decreases and is clamped at the top of the screen.
   assign w_nextX  = r_ballX + {4'b0, r_dx};
   assign w_sumY   = {1'b0, r_ballY} + {4'b0, r_dy};
   assign w_bounce = ~r_dirUp && (w_sumY >= LP_GROUND_Y);

   always_comb begin
      w_nextY = r_ballY;
      if (!r_dirUp) begin
         w_nextY = w_bounce ? LP_GROUND_Y[6:0] : w_sumY[6:0];
      end else if (r_ballY >= {3'b0, r_dy}) begin
         w_nextY = r_ballY - {3'b0, r_dy};
      end else begin
         w_nextY = 7'd0;
      end
   end

   // A struck ball travels back toward the bowler, stopping at x=0.
   assign w_backX = (r_ballX >= {4'b0, r_dx}) ? (r_ballX - {4'b0, r_dx}) : 8'd0;

   // Delivery state machine. All outputs are registered here; accept and
   // result_valid default low so they only ever pulse for one clock.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_dx          <= 4'd0;
         r_dy          <= 4'd0;
         r_ballX       <= LP_X_START;
         r_ballY       <= LP_Y_START;
         r_dirUp       <= 1'b0;
         r_swingPrev   <= 1'b0;
         r_swung       <= 1'b0;
         r_hitCnt      <= 8'd0;
         r_accept      <= 1'b0;
         r_busy        <= 1'b0;
         r_visible     <= 1'b0;
         r_resultValid <= 1'b0;
         r_runs        <= 3'd0;
         r_wicket      <= 1'b0;
      end else begin
         r_swingPrev   <= swing;
         r_accept      <= 1'b0;
         r_resultValid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (throw && !gameOver && (dx != 4'd0)) begin
                  r_dx      <= dx;
                  r_dy      <= dy;
                  r_ballX   <= LP_X_START;
                  r_ballY   <= LP_Y_START;
                  r_dirUp   <= 1'b0;
                  r_swung   <= 1'b0;
                  r_runs    <= 3'd0;
                  r_wicket  <= 1'b0;
                  r_accept  <= 1'b1;
                  r_busy    <= 1'b1;
                  r_visible <= 1'b1;
                  r_state   <= FLIGHT;
               end
            end
            FLIGHT: begin
               if (gameOver) begin
                  r_busy    <= 1'b0;
                  r_visible <= 1'b0;
                  r_state   <= IDLE;
               end else begin
                  if (w_swingFirst) begin
                     r_swung <= 1'b1;
                  end
                  // A hit wins over a coincident tick: the ball turns
                  // around from where the swing met it.
                  if (w_hitNow) begin
                     r_runs   <= w_hitRuns;
                     r_wicket <= 1'b0;
                     r_hitCnt <= 8'd0;
                     r_state  <= HIT;
                  end else if (tick) begin
                     r_ballX <= w_nextX;
                     r_ballY <= w_nextY;
                     if (w_bounce) begin
                        r_dirUp <= 1'b1;
                     end
                     if (w_nextX >= LP_STUMP_X) begin
                        r_wicket      <= (w_nextY >= LP_STUMP_TOP);
                        r_runs        <= 3'd0;
                        r_busy        <= 1'b0;
                        r_visible     <= 1'b0;
                        r_resultValid <= 1'b1;
                        r_state       <= RESULT;
                     end
                  end
               end
            end
            HIT: begin
               if (gameOver) begin
                  r_busy    <= 1'b0;
                  r_visible <= 1'b0;
                  r_state   <= IDLE;
               end else if (tick) begin
                  r_ballX <= w_backX;
                  if (r_hitCnt == LP_HIT_LAST) begin
                     r_busy        <= 1'b0;
                     r_visible     <= 1'b0;
                     r_resultValid <= 1'b1;
                     r_state       <= RESULT;
                  end else begin
                     r_hitCnt <= r_hitCnt + 8'd1;
                  end
               end
            end
            RESULT: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign accept       = r_accept;
   assign busy         = r_busy;
   assign ball_x       = r_ballX;
   assign ball_y       = r_ballY;
   assign ball_visible = r_visible;
   assign result_valid = r_resultValid;
   assign runs         = r_runs;
   assign wicket       = r_wicket;

endmodule

// File: tb/tb_ball_flight.sv
// Testbench for ball_flight: directed deliveries with hand-computed
// positions and outcomes.
module tb_ball_flight;

   logic       clock;
   logic       reset;
   logic       tick;
   logic       gameOver;
   logic       throw;
   logic [3:0] dy;
   logic [3:0] dx;
   logic       swing;
   logic       accept;
   logic       busy;
   logic [7:0] ball_x;
   logic [6:0] ball_y;
   logic       ball_visible;
   logic       result_valid;
   logic [2:0] runs;
   logic       wicket;

   int compareCount;
   int mismatchCount;

   ball_flight dut (
      .clock        (clock),
      .reset        (reset),
      .tick         (tick),
      .gameOver     (gameOver),
      .throw        (throw),
      .dy           (dy),
      .dx           (dx),
      .swing        (swing),
      .accept       (accept),
      .busy         (busy),
      .ball_x       (ball_x),
      .ball_y       (ball_y),
      .ball_visible (ball_visible),
      .result_valid (result_valid),
      .runs         (runs),
      .wicket       (wicket)
   );

   // Free-running 10 ns clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Counts one comparison and reports it when observed differs from expected
   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Issues a throw and checks the accept pulse; leaves the bench on a
   // negedge with the ball in FLIGHT at the release point
   task automatic applyStimulus(input logic [3:0] newDx, input logic [3:0] newDy);
      @(negedge clock);
      throw = 1'b1;
      dx    = newDx;
      dy    = newDy;
      @(negedge clock);
      checkOutput("accept_pulse", {7'd0, accept}, 8'd1);
      checkOutput("busy_flight", {7'd0, busy}, 8'd1);
      checkOutput("x_release", ball_x, 8'd16);
      throw = 1'b0;
      @(negedge clock);
      checkOutput("accept_drop", {7'd0, accept}, 8'd0);
   endtask

   // One-clock tick pulses, ending on the negedge after the last tick edge
   task automatic runTicks(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         tick = 1'b1;
         @(negedge clock);
         tick = 1'b0;
      end
   endtask

   task automatic pulseSwing();
      @(negedge clock);
      swing = 1'b1;
      @(negedge clock);
      swing = 1'b0;
   endtask

   // Checks the final outcome on the result pulse and its drop a clock later
   task automatic checkResult(input string tag, input logic [2:0] expRuns,
                              input logic expWicket);
      checkOutput({tag, "_valid"}, {7'd0, result_valid}, 8'd1);
      checkOutput({tag, "_runs"}, {5'd0, runs}, {5'd0, expRuns});
      checkOutput({tag, "_wicket"}, {7'd0, wicket}, {7'd0, expWicket});
      @(negedge clock);
      checkOutput({tag, "_valid_drop"}, {7'd0, result_valid}, 8'd0);
      checkOutput({tag, "_idle_busy"}, {7'd0, busy}, 8'd0);
   endtask

   initial begin
      compareCount  = 0;
      mismatchCount = 0;
      reset    = 1'b1;
      tick     = 1'b0;
      gameOver = 1'b0;
      throw    = 1'b0;
      dx       = 4'd0;
      dy       = 4'd0;
      swing    = 1'b0;

      // Reset state
      #12;
      checkOutput("rst_x", ball_x, 8'd16);
      checkOutput("rst_y", {1'b0, ball_y}, 8'd40);
      checkOutput("rst_busy", {7'd0, busy}, 8'd0);
      checkOutput("rst_visible", {7'd0, ball_visible}, 8'd0);
      checkOutput("rst_valid", {7'd0, result_valid}, 8'd0);
      checkOutput("rst_runs", {5'd0, runs}, 8'd0);
      checkOutput("rst_wicket", {7'd0, wicket}, 8'd0);
      @(negedge clock);
      reset = 1'b0;

      // Reset in the middle of a flight returns the ball immediately
      applyStimulus(4'd4, 4'd2);
      runTicks(10);
      checkOutput("mid_x", ball_x, 8'd56);
      checkOutput("mid_y", {1'b0, ball_y}, 8'd60);
      reset = 1'b1;
      #1;
      checkOutput("arst_x", ball_x, 8'd16);
      checkOutput("arst_y", {1'b0, ball_y}, 8'd40);
      checkOutput("arst_busy", {7'd0, busy}, 8'd0);
      checkOutput("arst_accept", {7'd0, accept}, 8'd0);
      @(negedge clock);
      reset = 1'b0;

      // Swing at x=120: first quarter of the window scores 1
      applyStimulus(4'd4, 4'd2);
      runTicks(26);
      checkOutput("pre_hit_x", ball_x, 8'd120);
      checkOutput("pre_hit_y", {1'b0, ball_y}, 8'd92);
      pulseSwing();
      checkOutput("hit_busy", {7'd0, busy}, 8'd1);
      runTicks(7);
      checkOutput("hit_no_valid_yet", {7'd0, result_valid}, 8'd0);
      runTicks(1);
      checkOutput("hit_back_x", ball_x, 8'd88);
      checkOutput("hit_hold_y", {1'b0, ball_y}, 8'd92);
      checkResult("hit1", 3'd1, 1'b0);

      // Swing at x=128: third quarter scores 6, ball returns to 96
      applyStimulus(4'd4, 4'd2);
      runTicks(28);
      checkOutput("pre_hit6_x", ball_x, 8'd128);
      pulseSwing();
      runTicks(8);
      checkOutput("hit6_back_x", ball_x, 8'd96);
      checkResult("hit6", 3'd6, 1'b0);

      // Swing on the same clock as the 26->27 tick is judged at x=120
      applyStimulus(4'd4, 4'd2);
      runTicks(26);
      @(negedge clock);
      tick  = 1'b1;
      swing = 1'b1;
      @(negedge clock);
      tick  = 1'b0;
      swing = 1'b0;
      checkOutput("coinc_runs", {5'd0, runs}, 8'd1);
      runTicks(8);
      checkResult("coinc", 3'd1, 1'b0);

      // No swing: bounce at tick 30, stumps hit at tick 34 with y=92
      applyStimulus(4'd4, 4'd2);
      runTicks(30);
      checkOutput("bounce_y", {1'b0, ball_y}, 8'd100);
      runTicks(3);
      checkOutput("t33_x", ball_x, 8'd148);
      checkOutput("t33_no_valid", {7'd0, result_valid}, 8'd0);
      runTicks(1);
      checkOutput("stump_x", ball_x, 8'd152);
      checkOutput("stump_y", {1'b0, ball_y}, 8'd92);
      checkResult("bowled", 3'd0, 1'b1);

      // Early swing at x=100 misses, delivery still bowls the batsman
      applyStimulus(4'd4, 4'd2);
      runTicks(21);
      checkOutput("miss_x", ball_x, 8'd100);
      pulseSwing();
      runTicks(13);
      checkResult("miss", 3'd0, 1'b1);

      // dy=4: bounce at tick 15, ball passes over the stumps at y=24
      applyStimulus(4'd4, 4'd4);
      runTicks(14);
      checkOutput("dy4_t14_y", {1'b0, ball_y}, 8'd96);
      runTicks(1);
      checkOutput("dy4_bounce", {1'b0, ball_y}, 8'd100);
      runTicks(19);
      checkOutput("dy4_x", ball_x, 8'd152);
      checkOutput("dy4_y", {1'b0, ball_y}, 8'd24);
      checkResult("dot", 3'd0, 1'b0);

      // dx=0 throw is rejected
      @(negedge clock);
      throw = 1'b1;
      dx    = 4'd0;
      dy    = 4'd2;
      @(negedge clock);
      checkOutput("dx0_accept", {7'd0, accept}, 8'd0);
      @(negedge clock);
      checkOutput("dx0_busy", {7'd0, busy}, 8'd0);
      throw = 1'b0;

      // gameOver aborts a flight without a result and blocks new throws
      applyStimulus(4'd4, 4'd2);
      runTicks(5);
      gameOver = 1'b1;
      @(negedge clock);
      checkOutput("abort_busy", {7'd0, busy}, 8'd0);
      checkOutput("abort_visible", {7'd0, ball_visible}, 8'd0);
      checkOutput("abort_valid", {7'd0, result_valid}, 8'd0);
      throw = 1'b1;
      dx    = 4'd4;
      @(negedge clock);
      checkOutput("go_accept", {7'd0, accept}, 8'd0);
      @(negedge clock);
      checkOutput("go_busy", {7'd0, busy}, 8'd0);
      throw    = 1'b0;
      gameOver = 1'b0;
      repeat (2) @(negedge clock);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
